// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register with stall hold, deferred branch flush,
// saturating stall/flush statistics and a stall watchdog.
module fd_pipe_reg #(
  parameter int unsigned       INS_W       = 32,
  parameter int unsigned       PC_W        = 7,
  parameter int unsigned       SEL_W       = 2,
  parameter logic [INS_W-1:0]  NOP_INS     = {INS_W{1'b0}},
  parameter int unsigned       CNT_W       = 8,
  parameter int unsigned       STALL_LIMIT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INS_W-1:0]  ins_i,
  input  logic [PC_W-1:0]   pc_plus1_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic [SEL_W-1:0]  pc_src_i,
  output logic [INS_W-1:0]  ins_o,
  output logic [PC_W-1:0]   pc_plus1_o,
  output logic              valid_o,
  output logic              bubble_o,
  output logic              flush_pend_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              stall_to_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);

  state_t           state_q;
  logic             redirect_c;
  logic             flush_req_c;
  logic [CNT_W-1:0] stall_cnt_nx_c;

  // The pending flush is exactly the HOLD_PEND state.
  assign flush_pend_o = (state_q == HOLD_PEND);
  assign redirect_c   = (pc_src_i != '0);
  assign flush_req_c  = redirect_c | flush_pend_o;

  // Consecutive-stall count for the upcoming edge; zero once the stall drops.
  always_comb begin
    stall_cnt_nx_c = '0;
    if (stall_i) begin
      stall_cnt_nx_c = (stall_cnt_o == CNT_MAX) ? stall_cnt_o
                                                : stall_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ins_o       <= NOP_INS;
      pc_plus1_o  <= '0;
      valid_o     <= 1'b0;
      bubble_o    <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      stall_to_o  <= 1'b0;
    end else begin
      stall_cnt_o <= stall_cnt_nx_c;
      stall_to_o  <= (stall_cnt_nx_c >= LIMIT);
      if (stall_i) begin
        // Redirects seen while stalled collapse into a single pending flush.
        state_q <= flush_req_c ? HOLD_PEND : HOLD;
      end else if (flush_req_c) begin
        state_q    <= FLUSH;
        ins_o      <= NOP_INS;
        pc_plus1_o <= '0;
        valid_o    <= 1'b0;
        bubble_o   <= 1'b1;
        if (flush_cnt_o != CNT_MAX) begin
          flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
      end else begin
        state_q    <= IDLE;
        ins_o      <= ins_i;
        pc_plus1_o <= pc_plus1_i;
        valid_o    <= valid_i;
        bubble_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Scoreboard bench for fd_pipe_reg: directed stimulus queues expected outputs,
// a monitor compares them one edge later.
module tb_fd_pipe_reg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned PC_W  = 7;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned LIM   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [INS_W-1:0]  ins_i;
  logic [PC_W-1:0]   pc_plus1_i;
  logic              valid_i;
  logic              stall_i;
  logic [SEL_W-1:0]  pc_src_i;
  logic [INS_W-1:0]  ins_o;
  logic [PC_W-1:0]   pc_plus1_o;
  logic              valid_o;
  logic              bubble_o;
  logic              flush_pend_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic              stall_to_o;

  fd_pipe_reg #(
    .INS_W(INS_W), .PC_W(PC_W), .SEL_W(SEL_W), .NOP_INS({INS_W{1'b0}}),
    .CNT_W(CNT_W), .STALL_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ins_i(ins_i), .pc_plus1_i(pc_plus1_i),
    .valid_i(valid_i), .stall_i(stall_i), .pc_src_i(pc_src_i),
    .ins_o(ins_o), .pc_plus1_o(pc_plus1_o), .valid_o(valid_o),
    .bubble_o(bubble_o), .flush_pend_o(flush_pend_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .stall_to_o(stall_to_o)
  );

  always #5 clk = ~clk;

  localparam int unsigned VW = INS_W + PC_W + 4 + 2*CNT_W + 1;

  typedef struct {
    int              id;
    logic [VW-1:0]   v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  function automatic logic [VW-1:0] pack_out();
    return {ins_o, pc_plus1_o, valid_o, bubble_o, flush_pend_o,
            stall_cnt_o, flush_cnt_o, stall_to_o};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response.
  task automatic step(input logic [INS_W-1:0] ins, input logic [PC_W-1:0] pc,
                      input logic v, input logic st, input logic [SEL_W-1:0] src,
                      input logic [INS_W-1:0] e_ins, input logic [PC_W-1:0] e_pc,
                      input logic e_v, input logic e_b, input logic e_p,
                      input logic [CNT_W-1:0] e_s, input logic [CNT_W-1:0] e_f,
                      input logic e_t);
    exp_t e;
    @(negedge clk);
    ins_i = ins; pc_plus1_i = pc; valid_i = v; stall_i = st; pc_src_i = src;
    e.id = step_id++;
    e.v  = {e_ins, e_pc, e_v, e_b, e_p, e_s, e_f, e_t};
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("step%0d", e.id), pack_out(), e.v);
    end
  end

  initial begin
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] f;
    rst_n = 1'b0;
    ins_i = '0; pc_plus1_i = '0; valid_i = 1'b0; stall_i = 1'b0; pc_src_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", pack_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load, direct flush, reload
    step(32'h1234_5678, 7'd5, 1, 0, 2'd0, 32'h1234_5678, 7'd5, 1, 0, 0, 3'd0, 3'd0, 0);
    step(32'hFFFF_0000, 7'd9, 1, 0, 2'd1, 32'h0, 7'd0, 0, 1, 0, 3'd0, 3'd1, 0);
    step(32'hAAAA_0001, 7'd6, 1, 0, 2'd0, 32'hAAAA_0001, 7'd6, 1, 0, 0, 3'd0, 3'd1, 0);

    // Deferred flush: redirect on stall cycle 2, applied on release
    step(32'h1111_1111, 7'd1, 1, 1, 2'd0, 32'hAAAA_0001, 7'd6, 1, 0, 0, 3'd1, 3'd1, 0);
    step(32'h2222_2222, 7'd2, 1, 1, 2'd2, 32'hAAAA_0001, 7'd6, 1, 0, 1, 3'd2, 3'd1, 0);
    step(32'h3333_3333, 7'd3, 1, 1, 2'd0, 32'hAAAA_0001, 7'd6, 1, 0, 1, 3'd3, 3'd1, 0);
    step(32'h4444_4444, 7'd4, 1, 0, 2'd0, 32'h0, 7'd0, 0, 1, 0, 3'd0, 3'd2, 0);
    step(32'hBBBB_0002, 7'd7, 0, 0, 2'd0, 32'hBBBB_0002, 7'd7, 0, 0, 0, 3'd0, 3'd2, 0);

    // Watchdog: six stalled cycles, asserted from the fourth
    for (int i = 1; i <= 6; i++) begin
      s = CNT_W'(i);
      step(32'h5555_5555, 7'd11, 1, 1, 2'd0, 32'hBBBB_0002, 7'd7, 0, 0, 0,
           s, 3'd2, (i >= 4));
    end
    step(32'hCCCC_0003, 7'd8, 1, 0, 2'd0, 32'hCCCC_0003, 7'd8, 1, 0, 0, 3'd0, 3'd2, 0);

    // Several redirects in one stall plus one on release give a single flush
    step(32'h6666_6666, 7'd12, 1, 1, 2'd3, 32'hCCCC_0003, 7'd8, 1, 0, 1, 3'd1, 3'd2, 0);
    step(32'h7777_7777, 7'd13, 1, 1, 2'd2, 32'hCCCC_0003, 7'd8, 1, 0, 1, 3'd2, 3'd2, 0);
    step(32'h8888_8888, 7'd14, 1, 0, 2'd1, 32'h0, 7'd0, 0, 1, 0, 3'd0, 3'd3, 0);

    // Flush counter saturates at 7
    for (int i = 1; i <= 10; i++) begin
      f = (3 + i > 7) ? 3'd7 : CNT_W'(3 + i);
      step(32'h9999_9999, 7'd15, 1, 0, 2'd1, 32'h0, 7'd0, 0, 1, 0, 3'd0, f, 0);
    end

    // Stall counter saturates at 7 while a flush is pending
    for (int i = 1; i <= 10; i++) begin
      s = (i > 7) ? 3'd7 : CNT_W'(i);
      step(32'hEEEE_EEEE, 7'd16, 1, 1, (i == 1) ? 2'd1 : 2'd0,
           32'h0, 7'd0, 0, 1, 1, s, 3'd7, (i >= 4));
    end

    // Asynchronous reset between edges drops the pending flush
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", pack_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'hDDDD_0004, 7'd9, 1, 0, 2'd0, 32'hDDDD_0004, 7'd9, 1, 0, 0, 3'd0, 3'd0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
